// File: rtl/rtc_bus_scheduler_if.sv
// rtc_bus_scheduler_if: requester handshake and RTC bus
// signals of the RTC bus scheduler.
interface rtc_bus_scheduler_if;
  logic       req_wr;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       req_rd;
  logic [7:0] rd_addr;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic [5:0] cont;
  logic       busy;
  logic       grant_wr;
  logic       grant_rd;
  logic       done_wr;
  logic       done_rd;
  logic [7:0] rd_data;

  modport slave (
    input  req_wr, wr_addr, wr_data,
    input  req_rd, rd_addr, bus_in,
    output bus_out, bus_oe,
    output cs_n, ad_n, wr_n, rd_n,
    output cont, busy,
    output grant_wr, grant_rd,
    output done_wr, done_rd,
    output rd_data
  );

  modport master (
    output req_wr, wr_addr, wr_data,
    output req_rd, rd_addr, bus_in,
    input  bus_out, bus_oe,
    input  cs_n, ad_n, wr_n, rd_n,
    input  cont, busy,
    input  grant_wr, grant_rd,
    input  done_wr, done_rd,
    input  rd_data
  );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: arbitrates write/read requesters and
// runs one fixed-length strobe sequence on the RTC bus.
module rtc_bus_scheduler #(
  parameter int unsigned T_LAST  = 42,
  parameter int unsigned CAP_CYC = 35
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_scheduler_if.slave bus_if
);

  localparam logic [5:0] C_LAST = 6'(T_LAST);
  localparam logic [5:0] C_CAP  = 6'(CAP_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cont_q, cont_d;
  logic       op_wr_q, op_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       last_wr_q, last_wr_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       busy_q, busy_d;
  logic       gnt_wr_q, gnt_wr_d;
  logic       gnt_rd_q, gnt_rd_d;
  logic       done_wr_q, done_wr_d;
  logic       done_rd_q, done_rd_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_n_q, ad_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;
  logic       pick_wr, pick_rd, start;

  // Arbitration: write wins ties unless it won the last grant.
  always_comb begin
    pick_wr = bus_if.req_wr &&
              !(bus_if.req_rd && last_wr_q);
    pick_rd = bus_if.req_rd && !pick_wr;
    start   = pick_wr || pick_rd;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = XFER;
      XFER: if (cont_q == C_LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, latches, handshake pulses and read capture.
  always_comb begin
    cont_d    = '0;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_wr_d = last_wr_q;
    rd_data_d = rd_data_q;
    gnt_wr_d  = 1'b0;
    gnt_rd_d  = 1'b0;
    if (state_q == IDLE && start) begin
      op_wr_d   = pick_wr;
      addr_d    = pick_wr ? bus_if.wr_addr
                          : bus_if.rd_addr;
      if (pick_wr) data_d = bus_if.wr_data;
      last_wr_d = pick_wr;
      gnt_wr_d  = pick_wr;
      gnt_rd_d  = pick_rd;
    end
    if (state_q == XFER && state_d == XFER)
      cont_d = cont_q + 6'd1;
    if (state_q == XFER && !op_wr_q &&
        cont_q == C_CAP)
      rd_data_d = bus_if.bus_in;
    done_wr_d = (state_q == DONE) && op_wr_q;
    done_rd_d = (state_q == DONE) && !op_wr_q;
    busy_d    = (state_d == XFER);
  end

  // Strobe/bus decode of the next counter value, so the
  // registered strobes line up with the cont they belong to.
  always_comb begin
    cs_n_d = 1'b1;
    ad_n_d = 1'b1;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    oe_d   = 1'b0;
    out_d  = '0;
    if (state_d == XFER) begin
      if (cont_d >= 6'd1 && cont_d <= 6'd40)
        cs_n_d = 1'b0;
      unique case (1'b1)
        (cont_d >= 6'd1 && cont_d <= 6'd20): begin
          ad_n_d = 1'b0;
          oe_d   = 1'b1;
          out_d  = addr_d;
        end
        (cont_d >= 6'd22 && cont_d <= 6'd40): begin
          if (op_wr_d) begin
            oe_d  = 1'b1;
            out_d = data_d;
          end
        end
        default: ;
      endcase
      if (cont_d >= 6'd5 && cont_d <= 6'd15)
        wr_n_d = 1'b0;
      if (cont_d >= 6'd26 && cont_d <= 6'd36) begin
        if (op_wr_d) wr_n_d = 1'b0;
        else         rd_n_d = 1'b0;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cont_q    <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      last_wr_q <= 1'b0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      gnt_wr_q  <= 1'b0;
      gnt_rd_q  <= 1'b0;
      done_wr_q <= 1'b0;
      done_rd_q <= 1'b0;
      cs_n_q    <= 1'b1;
      ad_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      oe_q      <= 1'b0;
      out_q     <= '0;
    end else begin
      cont_q    <= cont_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      last_wr_q <= last_wr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      gnt_wr_q  <= gnt_wr_d;
      gnt_rd_q  <= gnt_rd_d;
      done_wr_q <= done_wr_d;
      done_rd_q <= done_rd_d;
      cs_n_q    <= cs_n_d;
      ad_n_q    <= ad_n_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
    end
  end

  assign bus_if.cont     = cont_q;
  assign bus_if.busy     = busy_q;
  assign bus_if.grant_wr = gnt_wr_q;
  assign bus_if.grant_rd = gnt_rd_q;
  assign bus_if.done_wr  = done_wr_q;
  assign bus_if.done_rd  = done_rd_q;
  assign bus_if.rd_data  = rd_data_q;
  assign bus_if.cs_n     = cs_n_q;
  assign bus_if.ad_n     = ad_n_q;
  assign bus_if.wr_n     = wr_n_q;
  assign bus_if.rd_n     = rd_n_q;
  assign bus_if.bus_oe   = oe_q;
  assign bus_if.bus_out  = out_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler: directed and random requests checked
// every cycle against a transaction-timeline model.
module tb_rtc_bus_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  rtc_bus_scheduler_if u_if ();

  rtc_bus_scheduler #(
    .T_LAST (42),
    .CAP_CYC(35)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(u_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h want %0h",
                 nm, $time, act, exp);
    end
  endtask

  // Model: m_t counts cycles since the grant edge.
  // 0..42 = transfer with cont=m_t, 43 = done-state cycle,
  // 44 = idle cycle carrying the done pulse, -1 = idle.
  int         m_t    = -1;
  bit         m_op   = 1'b0;
  bit         m_last = 1'b0;
  bit         m_pw   = 1'b0;
  logic [7:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [7:0] m_rd   = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_t    <= -1;
      m_last <= 1'b0;
      m_rd   <= '0;
    end else begin
      if (m_t >= 0 && m_t <= 43) begin
        m_t <= m_t + 1;
      end else if (u_if.req_wr || u_if.req_rd) begin
        m_pw = u_if.req_wr && !(u_if.req_rd && m_last);
        m_op   <= m_pw;
        m_addr <= m_pw ? u_if.wr_addr : u_if.rd_addr;
        if (m_pw) m_data <= u_if.wr_data;
        m_last <= m_pw;
        m_t    <= 0;
      end else begin
        m_t <= -1;
      end
      if (m_t == 35 && !m_op) m_rd <= u_if.bus_in;
    end
  end

  bit         x_on, e_oe, e_cs, e_ad, e_wr, e_rd;
  logic [7:0] e_out;

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    x_on = (m_t >= 0 && m_t <= 42);
    e_cs = !(x_on && m_t >= 1 && m_t <= 40);
    e_ad = !(x_on && m_t >= 1 && m_t <= 20);
    e_oe = x_on && ((m_t >= 1 && m_t <= 20) ||
           (m_op && m_t >= 22 && m_t <= 40));
    e_out = (m_t <= 20) ? m_addr : m_data;
    e_wr = !(x_on && ((m_t >= 5 && m_t <= 15) ||
           (m_op && m_t >= 26 && m_t <= 36)));
    e_rd = !(x_on && !m_op && m_t >= 26 && m_t <= 36);
    chk("cont", int'(u_if.cont), x_on ? m_t : 0);
    chk("busy", int'(u_if.busy), int'(x_on));
    chk("cs_n", int'(u_if.cs_n), int'(e_cs));
    chk("ad_n", int'(u_if.ad_n), int'(e_ad));
    chk("wr_n", int'(u_if.wr_n), int'(e_wr));
    chk("rd_n", int'(u_if.rd_n), int'(e_rd));
    chk("bus_oe", int'(u_if.bus_oe), int'(e_oe));
    if (e_oe) chk("bus_out", int'(u_if.bus_out), int'(e_out));
    chk("grant_wr", int'(u_if.grant_wr), int'(m_t == 0 && m_op));
    chk("grant_rd", int'(u_if.grant_rd), int'(m_t == 0 && !m_op));
    chk("done_wr", int'(u_if.done_wr), int'(m_t == 44 && m_op));
    chk("done_rd", int'(u_if.done_rd), int'(m_t == 44 && !m_op));
    chk("rd_data", int'(u_if.rd_data), int'(m_rd));
    chk("excl", int'(u_if.wr_n | u_if.rd_n), 1);
    chk("rd_oe", int'(!(!u_if.rd_n && u_if.bus_oe)), 1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic txn(input bit wr, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] bin);
    int gc = -1, dc = -1, rdlow = 0, wrlow = 0, oebad = 0;
    u_if.bus_in = bin;
    if (wr) begin
      u_if.wr_addr = a;
      u_if.wr_data = d;
      u_if.req_wr  = 1'b1;
    end else begin
      u_if.rd_addr = a;
      u_if.req_rd  = 1'b1;
    end
    for (int i = 0; i < 200 && dc < 0; i++) begin
      tick();
      if (wr ? u_if.grant_wr : u_if.grant_rd) gc = cyc;
      if (u_if.busy) begin
        if (u_if.cont == 6'd10) begin
          chk("lit_addr", int'(u_if.bus_out), int'(a));
          chk("lit_ad_n", int'(u_if.ad_n), 0);
          chk("lit_wr_n_a", int'(u_if.wr_n), 0);
        end
        if (wr && u_if.cont == 6'd30) begin
          chk("lit_data", int'(u_if.bus_out), int'(d));
          chk("lit_wr_n_d", int'(u_if.wr_n), 0);
        end
        if (!u_if.rd_n) rdlow++;
        if (!u_if.wr_n && u_if.cont >= 6'd26) wrlow++;
        if (!wr && u_if.cont >= 6'd21 && u_if.bus_oe) oebad++;
      end
      if (wr ? u_if.done_wr : u_if.done_rd) begin
        dc = cyc;
        if (wr) u_if.req_wr = 1'b0;
        else    u_if.req_rd = 1'b0;
      end
    end
    chk("lit_done_seen", int'(dc >= 0 && gc >= 0), 1);
    chk("lit_latency", dc - gc, 44);
    chk("lit_data_strobe", wr ? wrlow : rdlow, 11);
    chk("lit_other_strobe", wr ? rdlow : wrlow, 0);
    chk("lit_rd_oe_off", oebad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  ord[$];
    bit  exp_ord[4];
    int  ng, nd, gw;
    bit  cur, rw, rr, hit;

    u_if.req_wr  = 1'b0;
    u_if.req_rd  = 1'b0;
    u_if.wr_addr = '0;
    u_if.wr_data = '0;
    u_if.rd_addr = '0;
    u_if.bus_in  = '0;
    repeat (3) tick();
    chk("lit_rst_cs", int'(u_if.cs_n), 1);
    chk("lit_rst_oe", int'(u_if.bus_oe), 0);
    chk("lit_rst_busy", int'(u_if.busy), 0);
    chk("lit_rst_rd", int'(u_if.rd_data), 0);
    reset = 1'b1;
    tick();

    // Single write, then read, then write leaving rd_data alone.
    txn(1'b1, 8'h02, 8'h45, 8'h00);
    tick();
    txn(1'b0, 8'h01, 8'h00, 8'h37);
    chk("lit_rd_data", int'(u_if.rd_data), 8'h37);
    tick();
    txn(1'b1, 8'h10, 8'h99, 8'h55);
    chk("lit_rd_kept", int'(u_if.rd_data), 8'h37);

    // Contention: both held, expect W,R,W,R.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
    ng = 0; nd = 0; rw = 0; rr = 0; cur = 0;
    u_if.wr_addr = 8'h20;
    u_if.wr_data = 8'h21;
    u_if.rd_addr = 8'h22;
    u_if.req_wr  = 1'b1;
    u_if.req_rd  = 1'b1;
    for (int i = 0; i < 400 && nd < 4; i++) begin
      tick();
      if (u_if.grant_wr || u_if.grant_rd) begin
        cur = u_if.grant_wr;
        ord.push_back(int'(cur));
        ng++;
      end
      if (rw && ng < 4) u_if.req_wr = 1'b1;
      if (rr && ng < 4) u_if.req_rd = 1'b1;
      rw = 0;
      rr = 0;
      if (u_if.done_wr) begin
        chk("lit_done_match_w", int'(cur), 1);
        u_if.req_wr = 1'b0;
        rw = 1;
        nd++;
      end
      if (u_if.done_rd) begin
        chk("lit_done_match_r", int'(cur), 0);
        u_if.req_rd = 1'b0;
        rr = 1;
        nd++;
      end
    end
    u_if.req_wr = 1'b0;
    u_if.req_rd = 1'b0;
    repeat (5) tick();
    chk("lit_grant_count", ord.size(), 4);
    if (ord.size() == 4)
      for (int k = 0; k < 4; k++)
        chk("lit_order", ord[k], int'(exp_ord[k]));

    // Reset at cont 28 of a write; pending read served after.
    u_if.wr_addr = 8'h33;
    u_if.wr_data = 8'h44;
    u_if.req_wr  = 1'b1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (u_if.busy && u_if.cont == 6'd28) hit = 1;
    end
    chk("lit_reach_28", int'(hit), 1);
    u_if.req_wr  = 1'b0;
    u_if.rd_addr = 8'h05;
    u_if.bus_in  = 8'h6c;
    u_if.req_rd  = 1'b1;
    reset = 1'b0;
    #1;
    chk("lit_mr_strobes", int'({u_if.cs_n, u_if.ad_n,
        u_if.wr_n, u_if.rd_n}), 4'hf);
    chk("lit_mr_oe", int'(u_if.bus_oe), 0);
    chk("lit_mr_busy", int'(u_if.busy), 0);
    tick();
    tick();
    reset = 1'b1;
    hit = 0;
    gw = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (u_if.grant_rd) gw++;
      if (u_if.done_rd) begin
        hit = 1;
        u_if.req_rd = 1'b0;
      end
    end
    chk("lit_mr_served", int'(hit) + gw, 2);
    chk("lit_mr_rd_data", int'(u_if.rd_data), 8'h6c);

    // Write request dropped before it is ever granted.
    gw = 0;
    hit = 0;
    u_if.rd_addr = 8'h07;
    u_if.req_rd  = 1'b1;
    for (int i = 0; i < 120 && !hit; i++) begin
      tick();
      if (u_if.grant_wr) gw++;
      if (u_if.busy && u_if.cont == 6'd3) u_if.req_wr = 1'b1;
      if (u_if.busy && u_if.cont == 6'd8) u_if.req_wr = 1'b0;
      if (u_if.done_rd) begin
        hit = 1;
        u_if.req_rd = 1'b0;
      end
    end
    repeat (10) begin
      tick();
      if (u_if.grant_wr) gw++;
    end
    chk("lit_drop_done", int'(hit), 1);
    chk("lit_drop_no_grant", gw, 0);

    // Random mix of 200 transactions.
    nd = 0;
    for (int i = 0; i < 30000 && nd < 200; i++) begin
      tick();
      u_if.bus_in = 8'($urandom);
      if (u_if.done_wr || u_if.done_rd) nd++;
      if (u_if.done_wr) u_if.req_wr = 1'b0;
      else if (!u_if.req_wr && $urandom_range(3) == 0) begin
        u_if.wr_addr = 8'($urandom);
        u_if.wr_data = 8'($urandom);
        u_if.req_wr  = 1'b1;
      end else if (u_if.req_wr && $urandom_range(31) == 0)
        u_if.req_wr = 1'b0;
      if (u_if.done_rd) u_if.req_rd = 1'b0;
      else if (!u_if.req_rd && $urandom_range(3) == 0) begin
        u_if.rd_addr = 8'($urandom);
        u_if.req_rd  = 1'b1;
      end else if (u_if.req_rd && $urandom_range(31) == 0)
        u_if.req_rd = 1'b0;
    end
    chk("lit_rand_done", int'(nd >= 200), 1);
    u_if.req_wr = 1'b0;
    u_if.req_rd = 1'b0;
    repeat (50) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Owns the multiplexed address/data bus of the RTC.
- Arbitrates between two requesters: the configuration write path (set time/date/alarm registers) and the periodic read path (refresh of displayed time).
- For each granted request it runs one fixed-length bus transaction: it generates the transaction counter, the active-low RTC strobes and the bus output/enable, and returns a done pulse, plus read data for reads.

Parameters:
- T_LAST, 42: last counter value of a transaction; counter runs 0..T_LAST.
- CAP_CYC, 35: counter value at which bus_in is captured on reads.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_wr  in  1  write request level; held until done_wr.
- wr_addr  in  8  RTC register address for the write.
- wr_data  in  8  BCD data to write.
- req_rd  in  1  read request level; held until done_rd.
- rd_addr  in  8  RTC register address for the read.
- bus_in  in  8  RTC bus sampled value.
- bus_out  out  8  value driven on the RTC bus.
- bus_oe  out  1  1 = drive bus_out; 0 = tri-state.
- cs_n, ad_n, wr_n, rd_n  out  1 each  RTC strobes, active low.
- cont  out  6  transaction counter.
- busy  out  1  high while a transaction is in progress.
- grant_wr, grant_rd  out  1 each  one-cycle acceptance pulse.
- done_wr, done_rd  out  1 each  one-cycle completion pulse.
- rd_data  out  8  last captured read byte.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - State goes to IDLE; cont=0; bus_out=0; bus_oe=0.
  - cs_n, ad_n, wr_n and rd_n are all 1.
  - busy, grants and dones are 0; rd_data=0; last_was_wr=0.
- States: IDLE, XFER, DONE.
- IDLE:
  - With no request pending, the block stays in IDLE and all strobes are inactive.
  - With a request pending at a clk edge, the block latches the address (and data for writes) and the operation type.
  - On that edge it pulses the matching grant for one cycle, sets busy=1, sets cont=0 and enters XFER.
- Arbitration:
  - Only one request pending: that request wins.
  - Both pending: write wins unless last_was_wr=1, in which case read wins. Back-to-back contention therefore alternates W,R,W,R.
  - last_was_wr is updated at every grant.
- XFER: cont increments every cycle. Strobes and bus are a registered decode of cont and the latched operation:
  - cs_n=0 for cont 1..40.
  - Address phase:
    - ad_n=0 for cont 1..20.
    - bus_oe=1 and bus_out=latched address for cont 1..20.
    - wr_n=0 for cont 5..15.
  - Cont 21 is turnaround: bus_oe=0.
  - Write data phase:
    - bus_oe=1 and bus_out=latched data for cont 22..40.
    - wr_n=0 for cont 26..36.
  - Read data phase:
    - bus_oe=0 for cont 21..42.
    - rd_n=0 for cont 26..36.
    - At cont==CAP_CYC, rd_data<=bus_in.
  - wr_n and rd_n are never low in the same cycle.
  - rd_n is never low while bus_oe=1.
  - At cont==T_LAST the block goes to DONE.
- DONE (one cycle):
  - Pulses done_wr or done_rd, clears busy, sets cont=0, all strobes inactive, then returns to IDLE.
  - A request still high in the IDLE cycle that follows DONE starts a new transaction. Requesters must drop the request on done.
- Latency: the grant pulse is asserted T_LAST+2 = 44 cycles before the done pulse.
- Request changes during XFER have no effect: the latched values are used.
- rd_data holds its value until the next read capture; writes never alter it.
- A request deasserted before it is granted is never served.

Test Plan:
- Write: reset, then req_wr=1, wr_addr=8'h02, wr_data=8'h45 -> grant_wr pulse; bus_out=02 with ad_n=0 and wr_n low at cont 5..15; bus_out=45 with wr_n low at cont 26..36; done_wr pulse 44 cycles after grant; rd_n=1 throughout.
- Read: req_rd=1, rd_addr=8'h01, bus_in=8'h37 during cont 26..36 -> rd_n low at cont 26..36; bus_oe=0 from cont 21; rd_data=37 at done_rd; rd_data unchanged after a following write.
- Contention: req_wr and req_rd held high for four transactions -> grant order W,R,W,R; no overlap of busy periods; each done pulse matches its grant.
- Mid-transaction reset: drive reset=0 at cont=28 of a write -> in the same cycle all strobes=1, bus_oe=0, busy=0; after release, a pending req_rd is served normally.
- Request dropped before grant: req_wr raised and lowered during another transaction -> no grant_wr ever issued.
- Strobe exclusivity: over a randomized 200-transaction mix, assert wr_n|rd_n is never 0, and rd_n=0 implies bus_oe=0.
